// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar ping sequencer.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PING    = 3'd1,
    ST_BLANK   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int CLK_HZ      = 24_000_000;
  localparam int TX_HZ       = 40_000;
  localparam int TX_HALF_DEF = CLK_HZ / (2 * TX_HZ);

  // Ping-pong scan step; returns {direction_up, next_angle}.
  function automatic logic [8:0] angle_step(input logic [7:0] a, input logic up,
                                            input logic [7:0] amax);
    logic [7:0] n;
    logic       u;
    if (up) begin
      n = a + 8'd1;
      u = (n != amax);
    end else begin
      n = a - 8'd1;
      u = (n == 8'd0);
    end
    return {u, n};
  endfunction

endpackage

// File: rtl/sonar_ping_sequencer_if.sv
// Front-end, frame buffer and consumer signals of the sonar ping sequencer.
interface sonar_ping_sequencer_if #(parameter int ADDR_W = 10);
  logic              enable;
  logic              adc_sample_clk;
  logic [7:0]        adc_sample;
  logic              tx_p;
  logic              tx_n;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              frame_ready;
  logic              frame_ack;
  logic [7:0]        angle;
  logic              busy;

  modport master (
    input  enable, adc_sample_clk, adc_sample, frame_ack,
    output tx_p, tx_n, buf_we, buf_addr, buf_data, frame_ready, angle, busy
  );

  modport slave (
    output enable, adc_sample_clk, adc_sample, frame_ack,
    input  tx_p, tx_n, buf_we, buf_addr, buf_data, frame_ready, angle, busy
  );
endinterface

// File: rtl/sonar_tx_burst.sv
// Differential transmit burst: 2*TX_CYCLES half-periods of TX_HALF clocks,
// tx_p high first, done pulses in the final burst cycle.
module sonar_tx_burst
  import sonar_pkg::*;
#(
  parameter int TX_HALF   = TX_HALF_DEF,
  parameter int TX_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_tx_p,
  output logic o_tx_n,
  output logic o_done
);

  localparam int HW = (TX_HALF > 1) ? $clog2(TX_HALF) : 1;
  localparam int PHASES = 2 * TX_CYCLES;
  localparam int PW = $clog2(PHASES);
  localparam logic [HW-1:0] HALF_LAST  = HW'(TX_HALF - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);

  logic          r_active;
  logic [HW-1:0] r_half;
  logic [PW-1:0] r_phase;
  logic          r_tx_p;
  logic          r_tx_n;
  logic          w_half_end;

  assign w_half_end = (r_half == HALF_LAST);
  assign o_done     = r_active & w_half_end & (r_phase == PHASE_LAST);
  assign o_tx_p     = r_tx_p;
  assign o_tx_n     = r_tx_n;

  // Half-period and phase counters with the registered drive legs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_half   <= '0;
      r_phase  <= '0;
      r_tx_p   <= 1'b0;
      r_tx_n   <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_half   <= '0;
      r_phase  <= '0;
      r_tx_p   <= 1'b1;
      r_tx_n   <= 1'b0;
    end else if (r_active) begin
      if (w_half_end) begin
        r_half <= '0;
        if (r_phase == PHASE_LAST) begin
          r_active <= 1'b0;
          r_phase  <= '0;
          r_tx_p   <= 1'b0;
          r_tx_n   <= 1'b0;
        end else begin
          r_phase <= r_phase + PW'(1);
          r_tx_p  <= ~r_tx_p;
          r_tx_n  <= r_tx_p;
        end
      end else begin
        r_half <= r_half + HW'(1);
      end
    end
  end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// One sonar measurement per scan step: burst, blank ring-down, capture
// samples to RAM, hand the frame over, then step the ping-pong scan angle.
module sonar_ping_sequencer
  import sonar_pkg::*;
#(
  parameter int TX_HALF       = TX_HALF_DEF,
  parameter int TX_CYCLES     = 8,
  parameter int BLANK_SAMPLES = 16,
  parameter int NUM_SAMPLES   = 1024,
  parameter int ADDR_W        = 10,
  parameter int ANGLE_MAX     = 180
) (
  input logic clk,
  input logic rst_n,
  sonar_ping_sequencer_if.master bus
);

  localparam int BW = (BLANK_SAMPLES > 1) ? $clog2(BLANK_SAMPLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_SAMPLES > 0) ? BLANK_SAMPLES - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_SAMPLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_smp_prev;
  logic [BW-1:0]     r_blank_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_angle;
  logic              r_dir_up;
  logic              w_edge;
  logic              w_start;
  logic              w_we;
  logic              w_ack;
  logic              w_tx_p;
  logic              w_tx_n;
  logic              w_tx_done;

  sonar_tx_burst #(
    .TX_HALF   (TX_HALF),
    .TX_CYCLES (TX_CYCLES)
  ) u_burst (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .o_tx_p  (w_tx_p),
    .o_tx_n  (w_tx_n),
    .o_done  (w_tx_done)
  );

  assign w_edge = bus.adc_sample_clk & ~r_smp_prev;

  // Next-state decode plus the one-cycle start/write/ack strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_we        = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          w_start     = 1'b1;
          w_state_nxt = ST_PING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PING: begin
        if (w_tx_done) begin
          w_state_nxt = (BLANK_SAMPLES == 0) ? ST_CAPTURE : ST_BLANK;
        end else begin
          w_state_nxt = ST_PING;
        end
      end
      ST_BLANK: begin
        if (w_edge && (r_blank_cnt == BLANK_LAST)) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_CAPTURE: begin
        w_we = w_edge;
        if (w_edge && (r_idx == IDX_LAST)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (bus.frame_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobe history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_prev <= 1'b0;
    end else begin
      r_smp_prev <= bus.adc_sample_clk;
    end
  end

  // Discarded-edge counter; wraps to 0 on the edge that ends blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank_cnt <= '0;
    end else if ((r_state == ST_BLANK) && w_edge) begin
      r_blank_cnt <= (r_blank_cnt == BLANK_LAST) ? '0 : r_blank_cnt + BW'(1);
    end else begin
      r_blank_cnt <= r_blank_cnt;
    end
  end

  // Sample index; back to 0 after the last write of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_we) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + ADDR_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Scan angle advances once per acknowledged frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_angle  <= 8'd0;
      r_dir_up <= 1'b1;
    end else if (w_ack) begin
      {r_dir_up, r_angle} <= angle_step(r_angle, r_dir_up, 8'(ANGLE_MAX));
    end else begin
      r_angle  <= r_angle;
      r_dir_up <= r_dir_up;
    end
  end

  assign bus.tx_p        = w_tx_p;
  assign bus.tx_n        = w_tx_n;
  assign bus.buf_we      = w_we;
  assign bus.buf_addr    = r_idx;
  assign bus.buf_data    = w_we ? bus.adc_sample : 8'h00;
  assign bus.frame_ready = (r_state == ST_DONE);
  assign bus.angle       = r_angle;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Randomized bench for sonar_ping_sequencer with a phase-level reference model.
module tb_sonar_ping_sequencer;

  localparam int TXH = 3;
  localparam int TXC = 2;
  localparam int BLK = 2;
  localparam int NUM = 4;
  localparam int AW  = 3;
  localparam int AM  = 2;
  localparam int BURST = 2 * TXC * TXH;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   adc_mode;

  sonar_ping_sequencer_if #(.ADDR_W(AW)) bus ();

  sonar_ping_sequencer #(
    .TX_HALF       (TXH),
    .TX_CYCLES     (TXC),
    .BLANK_SAMPLES (BLK),
    .NUM_SAMPLES   (NUM),
    .ADDR_W        (AW),
    .ANGLE_MAX     (AM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 idle, 1 burst, 2 listening (blank+capture), 3 frame held.
  int   m_phase;
  int   m_off;
  int   m_edges;
  int   m_npings;
  logic m_prev;

  function automatic int angle_of(input int n);
    int p;
    p = n % (2 * AM);
    return (p <= AM) ? p : 2 * AM - p;
  endfunction

  function automatic logic exp_tx_p();
    return (m_phase == 1) && (((m_off / TXH) % 2) == 0);
  endfunction

  function automatic logic exp_we();
    return (m_phase == 2) && bus.adc_sample_clk && !m_prev && (m_edges >= BLK);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_off    <= 0;
      m_edges  <= 0;
      m_npings <= 0;
      m_prev   <= 1'b0;
    end else begin
      m_prev <= bus.adc_sample_clk;
      case (m_phase)
        0: if (bus.enable) begin m_phase <= 1; m_off <= 0; end
        1: if (m_off + 1 == BURST) begin m_phase <= 2; m_edges <= 0; end
           else m_off <= m_off + 1;
        2: if (bus.adc_sample_clk && !m_prev) begin
             m_edges <= m_edges + 1;
             if (m_edges + 1 == BLK + NUM) m_phase <= 3;
           end
        3: if (bus.frame_ack) begin m_phase <= 0; m_npings <= m_npings + 1; end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("tx_p", 32'(bus.tx_p), 32'(exp_tx_p()));
      chk("tx_n", 32'(bus.tx_n), 32'((m_phase == 1) && !exp_tx_p()));
      chk("frame_ready", 32'(bus.frame_ready), 32'(m_phase == 3));
      chk("angle", 32'(bus.angle), angle_of(m_npings));
      chk("buf_we", 32'(bus.buf_we), 32'(exp_we()));
      if (exp_we()) begin
        chk("buf_addr", 32'(bus.buf_addr), m_edges - BLK);
        chk("buf_data", 32'(bus.buf_data), 32'(bus.adc_sample));
      end
    end
  end

  // ADC strobe: 0 idle, 1 counting 0x10.. with 2-high/2-low, 2 random.
  initial begin : adc_gen
    int hi_left;
    int lo_left;
    logic [7:0] nextv;
    bus.adc_sample_clk = 1'b0;
    bus.adc_sample = 8'h00;
    hi_left = 0;
    lo_left = 0;
    nextv = 8'h10;
    forever begin
      @(posedge clk);
      #1;
      if (adc_mode == 0) begin
        bus.adc_sample_clk = 1'b0;
        nextv = 8'h10;
        hi_left = 0;
        lo_left = 0;
      end else if (hi_left > 0) begin
        hi_left = hi_left - 1;
        if (hi_left == 0) begin
          bus.adc_sample_clk = 1'b0;
          lo_left = (adc_mode == 1) ? 2 : int'($urandom_range(1, 3));
        end
      end else if (lo_left > 1) begin
        lo_left = lo_left - 1;
      end else begin
        bus.adc_sample_clk = 1'b1;
        bus.adc_sample = (adc_mode == 1) ? nextv : 8'($urandom);
        nextv = nextv + 8'd1;
        hi_left = (adc_mode == 1) ? 2 : int'($urandom_range(1, 3));
        lo_left = 0;
      end
    end
  end

  int         wr_a[$];
  logic [7:0] wr_d[$];
  int         angle_log[$];
  logic [11:0] pat_p;
  logic [11:0] pat_n;
  logic [7:0] exp_d[4];
  int         exp_ang[6];
  int         last_we_cyc;
  int         ready_cyc;
  int         cnt_ready;
  int         cnt_we;
  int         d;
  logic       got;
  logic       pre;
  logic       drop;
  logic       drop_now;

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    adc_mode = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.frame_ack = 1'b0;
    exp_d = '{8'h12, 8'h13, 8'h14, 8'h15};
    exp_ang = '{0, 1, 2, 1, 0, 1};
    last_we_cyc = 0;
    ready_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_tx", 32'({bus.tx_p, bus.tx_n}), 0);
    chk("rst_ready", 32'(bus.frame_ready), 0);
    chk("rst_angle", 32'(bus.angle), 0);

    // Directed ping: burst shape, blanking, capture of 0x12..0x15.
    @(posedge clk);
    #1 bus.enable = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat_p[11 - i] = bus.tx_p;
      pat_n[11 - i] = bus.tx_n;
    end
    chk("burst_tx_p", 32'(pat_p), 32'(12'b111000111000));
    chk("burst_tx_n", 32'(pat_n), 32'(12'b000111000111));
    @(negedge clk);
    chk("blank_tx", 32'({bus.tx_p, bus.tx_n}), 0);
    chk("blank_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1 adc_mode = 1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.buf_we) begin
        wr_a.push_back(int'(bus.buf_addr));
        wr_d.push_back(bus.buf_data);
        last_we_cyc = cyc;
      end
      if (bus.frame_ready) begin
        got = 1'b1;
        ready_cyc = cyc;
      end
    end
    if (!got) chk("ready_timeout", 0, 1);
    angle_log.push_back(int'(bus.angle));
    chk("write_count", wr_a.size(), 4);
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      chk("write_addr", wr_a[i], i);
      chk("write_data", 32'(wr_d[i]), 32'(exp_d[i]));
    end
    chk("ready_latency", ready_cyc - last_we_cyc, 1);

    // Frame held without ack while strobes keep arriving.
    cnt_ready = 0;
    cnt_we = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.frame_ready) cnt_ready++;
      if (bus.buf_we) cnt_we++;
    end
    chk("hold_ready", cnt_ready, 50);
    chk("hold_writes", cnt_we, 0);
    @(posedge clk);
    #1 begin bus.enable = 1'b0; bus.frame_ack = 1'b1; end
    @(posedge clk);
    #1 bus.frame_ack = 1'b0;
    @(negedge clk);
    chk("ack_ready", 32'(bus.frame_ready), 0);
    chk("ack_angle", 32'(bus.angle), 1);
    chk("ack_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1 adc_mode = 2;

    // Random pings: early/late ack, enable dropped during capture.
    for (int p = 1; p < 12; p++) begin
      pre = 1'($urandom_range(0, 1));
      drop = (p % 4 == 3);
      drop_now = 1'b0;
      got = 1'b0;
      bus.enable = 1'b1;
      bus.frame_ack = pre;
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge clk);
        if (bus.frame_ready) got = 1'b1;
        else begin
          if (drop && bus.buf_we) drop_now = 1'b1;
          @(posedge clk);
          #1;
          if (drop_now) bus.enable = 1'b0;
        end
      end
      if (!got) chk("ready_timeout", 0, 1);
      angle_log.push_back(int'(bus.angle));
      if (pre) begin
        @(posedge clk);
        #1 bus.frame_ack = 1'b0;
      end else begin
        d = int'($urandom_range(0, 3));
        repeat (d) @(posedge clk);
        @(posedge clk);
        #1 bus.frame_ack = 1'b1;
        @(posedge clk);
        #1 bus.frame_ack = 1'b0;
      end
      if (drop) begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("drop_busy", 32'(bus.busy), 0);
          chk("drop_tx", 32'({bus.tx_p, bus.tx_n}), 0);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      chk("angle_seq", (i < angle_log.size()) ? angle_log[i] : -1, exp_ang[i]);
    end

    // Asynchronous reset in the middle of a burst.
    @(posedge clk);
    #1 bus.enable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (bus.tx_p) got = 1'b1;
    end
    if (!got) chk("ping_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'({bus.tx_p, bus.tx_n}), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_angle", 32'(bus.angle), 0);
    chk("arst_ready", 32'(bus.frame_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("restart_idle", 32'(bus.busy), 0);
    @(negedge clk);
    chk("restart_tx_p", 32'(bus.tx_p), 1);
    chk("restart_busy", 32'(bus.busy), 1);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
